// File: rtl/inv_rr_scheduler_pkg.sv
// Shared definitions for the round-robin inverter scheduler: FSM state
// encodings and default parameter values.
package inv_rr_scheduler_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_RESP    = 2'd2;

endpackage

// File: rtl/inv_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping N_REQ-1 -> 0. Reusable by other shared-resource schedulers.
module rr_pick
   import inv_rr_scheduler_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDW   = $clog2(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IDW-1:0]   gnt_idx,
   output logic             any
);

   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_cand;

   // Wrap is an explicit subtract of N_REQ, so non-power-of-two N_REQ never
   // produces an index beyond N_REQ-1.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      w_sum      = '0;
      w_cand     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(N_REQ))
            w_sum = w_sum - (IDW+1)'(N_REQ);
         w_cand = w_sum[IDW-1:0];
         if (!any && req[w_cand]) begin
            any                = 1'b1;
            gnt_onehot[w_cand] = 1'b1;
            gnt_idx            = w_cand;
         end
      end
   end

endmodule

// File: rtl/inv_rr_scheduler.sv
// Round-robin scheduler sharing one registered WIDTH-bit inverter among
// N_REQ valid/ready requesters; IDLE -> COMPUTE -> RESP per transaction.
module inv_rr_scheduler
   import inv_rr_scheduler_pkg::*;
#(
   parameter  int N_REQ = DEF_N_REQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [IDW-1:0]         rsp_id,
   input  logic                   rsp_ready,
   output logic                   busy
);

   logic [1:0]       r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_win_p0;
   logic [WIDTH-1:0] r_op_p0;
   logic [WIDTH-1:0] r_result_p1;
   logic [IDW-1:0]   r_rsp_id_p1;
   logic             r_rsp_valid_p1;

   logic [N_REQ-1:0] w_gnt;
   logic [IDW-1:0]   w_gnt_idx;
   logic             w_any;
   logic             w_grant_en;
   logic [WIDTH-1:0] w_sel_data;
   logic [IDW-1:0]   w_ptr_next;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req        (req_valid),
      .ptr        (r_ptr),
      .gnt_onehot (w_gnt),
      .gnt_idx    (w_gnt_idx),
      .any        (w_any)
   );

   // Grant is gated by rst so no operand appears accepted while reset is held.
   assign w_grant_en = (r_state == S_IDLE) && w_any && !rst;
   assign req_ready  = w_grant_en ? w_gnt : '0;
   assign w_sel_data = req_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
   assign w_ptr_next = (r_win_p0 == IDW'(N_REQ-1)) ? '0 : r_win_p0 + IDW'(1);

   assign rsp_valid = r_rsp_valid_p1;
   assign rsp_data  = r_result_p1;
   assign rsp_id    = r_rsp_id_p1;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_ptr          <= '0;
         r_win_p0       <= '0;
         r_op_p0        <= '0;
         r_result_p1    <= '0;
         r_rsp_id_p1    <= '0;
         r_rsp_valid_p1 <= 1'b0;
      end else begin
         case (r_state)
            // p0: capture the winning operand and its index
            S_IDLE: begin
               if (w_any) begin
                  r_op_p0  <= w_sel_data;
                  r_win_p0 <= w_gnt_idx;
                  r_state  <= S_COMPUTE;
               end
            end
            // p1: inverter into the result register
            S_COMPUTE: begin
               r_result_p1    <= ~r_op_p0;
               r_rsp_id_p1    <= r_win_p0;
               r_rsp_valid_p1 <= 1'b1;
               r_state        <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid_p1 <= 1'b0;
                  r_ptr          <= w_ptr_next;
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_rr_scheduler.sv
// Directed scoreboard bench for inv_rr_scheduler (N_REQ=4 and N_REQ=3).
module tb_inv_rr_scheduler;

   logic        clk;
   logic        rst;

   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic        busy;

   logic [2:0]  b_req_valid;
   logic [23:0] b_req_data;
   logic [2:0]  b_req_ready;
   logic        b_rsp_valid;
   logic [7:0]  b_rsp_data;
   logic [1:0]  b_rsp_id;
   logic        b_rsp_ready;
   logic        b_busy;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_a[$];
   logic [9:0] exp_b[$];
   logic [9:0] e_a;
   logic [9:0] e_b;

   inv_rr_scheduler #(.N_REQ(4), .WIDTH(8)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   inv_rr_scheduler #(.N_REQ(3), .WIDTH(8)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .req_valid (b_req_valid),
      .req_data  (b_req_data),
      .req_ready (b_req_ready),
      .rsp_valid (b_rsp_valid),
      .rsp_data  (b_rsp_data),
      .rsp_id    (b_rsp_id),
      .rsp_ready (b_rsp_ready),
      .busy      (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Response monitors: pop the scoreboard on every accepted response.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && rsp_ready) begin
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_rsp got id %0d data %0h expected none", rsp_id, rsp_data);
            end else begin
               e_a = exp_a.pop_front();
               chk("a_rsp_id", 32'(rsp_id), 32'(e_a[9:8]));
               chk("a_rsp_data", 32'(rsp_data), 32'(e_a[7:0]));
            end
         end
         chk("a_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         chk("a_ready_outside_idle", 32'(busy && (req_ready != 4'd0)), 32'd0);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (b_rsp_valid && b_rsp_ready) begin
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_rsp got id %0d data %0h expected none", b_rsp_id, b_rsp_data);
            end else begin
               e_b = exp_b.pop_front();
               chk("b_rsp_id", 32'(b_rsp_id), 32'(e_b[9:8]));
               chk("b_rsp_data", 32'(b_rsp_data), 32'(e_b[7:0]));
            end
         end
         chk("b_ready_onehot0", 32'($onehot0(b_req_ready)), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         g2[5];
      logic [7:0] x2[5];
      int         g6[4];
      logic [7:0] x6[4];
      g2 = '{0, 1, 2, 3, 0};
      x2 = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hEE};
      g6 = '{0, 1, 2, 0};
      x6 = '{8'hEF, 8'hDF, 8'hCF, 8'hEF};

      rst         = 1'b1;
      req_valid   = 4'b0100;
      req_data    = 32'h00A5_0000;
      rsp_ready   = 1'b1;
      b_req_valid = 3'b000;
      b_req_data  = 24'h0;
      b_rsp_ready = 1'b1;
      step();
      step();

      // 1: reset state, then a single request from requester 2
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_b_busy", 32'(b_busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("t1_grant", 32'(req_ready), 32'h4);
      exp_a.push_back({2'd2, 8'h5A});
      step();
      req_valid = 4'b0000;
      #1;
      chk("t1_compute_ready", 32'(req_ready), 32'd0);
      chk("t1_compute_busy", 32'(busy), 32'd1);
      chk("t1_compute_valid", 32'(rsp_valid), 32'd0);
      step();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_data", 32'(rsp_data), 32'h5A);
      step();
      chk("t1_idle_valid", 32'(rsp_valid), 32'd0);
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // 2: all four requesting, ptr reset to 0
      rst = 1'b1;
      step();
      rst       = 1'b0;
      req_data  = 32'h4433_2211;
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("t2_idle_valid", 32'(rsp_valid), 32'd0);
         chk("t2_grant", 32'(req_ready), 32'd1 << g2[k]);
         exp_a.push_back({2'(g2[k]), x2[k]});
         step();
         chk("t2_compute_valid", 32'(rsp_valid), 32'd0);
         step();
         chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
         step();
         if (k == 4) req_valid = 4'h0;
         #1;
      end

      // 3: backpressure for 10 cycles; ptr is 1 here
      rsp_ready = 1'b0;
      req_data  = 32'h7700_3C00;
      req_valid = 4'b1010;
      #1;
      chk("t3_grant", 32'(req_ready), 32'h2);
      exp_a.push_back({2'd1, 8'hC3});
      step();
      step();
      for (int k = 0; k < 10; k++) begin
         chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t3_hold_data", 32'(rsp_data), 32'hC3);
         chk("t3_hold_id", 32'(rsp_id), 32'd1);
         chk("t3_hold_busy", 32'(busy), 32'd1);
         chk("t3_hold_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("t3_release_valid", 32'(rsp_valid), 32'd0);
      chk("t3_release_busy", 32'(busy), 32'd0);
      chk("t3_next_grant", 32'(req_ready), 32'h8);
      exp_a.push_back({2'd3, 8'h88});
      step();
      req_valid = 4'b0000;
      step();
      step();

      // 4: ptr -> 3 via requester 2, then wrap to 0, 1, and skip dropped 2
      req_data  = 32'h000F_0000;
      req_valid = 4'b0100;
      #1;
      chk("t4_pre_grant", 32'(req_ready), 32'h4);
      exp_a.push_back({2'd2, 8'hF0});
      step();
      req_valid = 4'b0000;
      step();
      step();
      req_data  = 32'h0099_0201;
      req_valid = 4'b0111;
      #1;
      chk("t4_wrap_grant", 32'(req_ready), 32'h1);
      exp_a.push_back({2'd0, 8'hFE});
      step();
      req_valid = 4'b0011;
      step();
      step();
      chk("t4_grant1", 32'(req_ready), 32'h2);
      exp_a.push_back({2'd1, 8'hFD});
      step();
      req_valid = 4'b0001;
      step();
      step();
      chk("t4_skip_grant", 32'(req_ready), 32'h1);
      exp_a.push_back({2'd0, 8'hFE});
      step();
      req_valid = 4'b0000;
      step();
      step();

      // 5: reset during COMPUTE discards the operand
      req_valid = 4'b0100;
      #1;
      chk("t5_grant", 32'(req_ready), 32'h4);
      step();
      req_valid = 4'b0000;
      chk("t5_compute_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_async_valid", 32'(rsp_valid), 32'd0);
      chk("t5_async_data", 32'(rsp_data), 32'd0);
      chk("t5_async_id", 32'(rsp_id), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      req_valid = 4'hF;
      #1;
      chk("t5_rst_ready", 32'(req_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("t5_post_valid", 32'(rsp_valid), 32'd0);
      chk("t5_ptr_zero_grant", 32'(req_ready), 32'h1);
      exp_a.push_back({2'd0, 8'hFE});
      step();
      req_valid = 4'b0000;
      chk("t5_no_stale_valid", 32'(rsp_valid), 32'd0);
      step();
      chk("t5_fresh_valid", 32'(rsp_valid), 32'd1);
      step();

      // 6: N_REQ=3, all requesting
      b_req_data  = 24'h30_2010;
      b_req_valid = 3'b111;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("t6_grant", 32'(b_req_ready), 32'd1 << g6[k]);
         exp_b.push_back({2'(g6[k]), x6[k]});
         step();
         chk("t6_compute_valid", 32'(b_rsp_valid), 32'd0);
         step();
         chk("t6_rsp_valid", 32'(b_rsp_valid), 32'd1);
         chk("t6_id_range", 32'(b_rsp_id == 2'd3), 32'd0);
         step();
         if (k == 3) b_req_valid = 3'b000;
         #1;
      end

      step();
      step();
      chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
      chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
